event_encoder: RTL and testbench
================================

EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 Parameter NUM_REQ, default 8, number of request lines; only 8 is supported.
REQ-002 Parameter CODE_W, default 3, width of the encoded output; equals log2(NUM_REQ).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 req  input  8  request lines; each bit sampled every cycle, any 1-cycle pulse counts as one event.
REQ-006 code  output  3  binary index of the issued request.
REQ-007 valid  output  1  code holds an issued event.
REQ-008 ready  input  1  consumer accepts code when valid and ready are both 1 at a rising edge.
REQ-009 pending  output  8  latched, not-yet-issued requests.
REQ-010 overflow  output  1  1-cycle pulse: an event was lost by merging into an already-pending bit.

Function
REQ-011 Each edge, pending SHALL update as: (pending with the bit being loaded into code cleared) OR req.
REQ-012 FSM states SHALL be IDLE (valid=0) and OUT (valid=1).
REQ-013 IDLE -> OUT when registered pending != 0: code loads the selected index; that pending bit clears in the same edge.
REQ-014 OUT with ready=0: code, valid, and the round-robin pointer SHALL hold unchanged.
REQ-015 OUT with ready=1: if registered pending != 0, reload code in the same edge and stay in OUT (back-to-back, no bubble); else go to IDLE.
REQ-016 Selection SHALL use registered pending only (the current-cycle req is excluded); latency from req edge to valid is 2 edges (pending at edge k, valid/code at edge k+1).
REQ-017 Selection is round-robin: search upward from ptr with wrap 7->0; first set bit wins.
REQ-018 ptr SHALL become (loaded code + 1) mod 8 on every load; ptr is unchanged when nothing is loaded.
REQ-019 overflow SHALL pulse when req[i]=1 and pending[i]=1 and bit i is not cleared in that edge.
REQ-020 Boundary: req[i] in the same cycle that bit i is loaded -> pending[i]=1 afterwards, no overflow.
REQ-021 Boundary: req[i] while code=i is in flight (OUT) -> new pending event, issued again later, no overflow.
REQ-022 Boundary: all 8 pending -> issued in wrap order starting at ptr, one per accepted handshake.

Reset
REQ-023 When rst_n=0 at an edge: state=IDLE, valid=0, code=0, pending=0, overflow=0, ptr=0.
REQ-024 Reset mid-operation SHALL discard in-flight and pending events without a handshake; req is ignored during the reset cycle.
REQ-025 After reset release, bit 0 has highest priority.

Structure
REQ-026 Shared package event_pkg SHALL hold NUM_REQ, CODE_W, and the state enum {IDLE, OUT}.
REQ-027 Sub-module rr_pick (combinational: pending, ptr -> index, found) SHALL hold the round-robin one-hot-to-binary encoding; the top level holds the FSM and registers.

Verification
REQ-028 Reset, then req=8'b0000_1000 for 1 cycle with ready=1 -> valid=1 and code=3 two edges later, valid=1 for exactly 1 cycle, pending=0.
REQ-029 req=8'b1000_0001 in one cycle with ready=1, ptr=0 -> code=0, then code=7 on consecutive cycles; valid stays 1 with no bubble.
REQ-030 req=8'hFF with ready=0 for 5 cycles -> code=0 held stable for all 5 cycles; pending=8'hFE; overflow pulses on each later repeat of bits 1-7.
REQ-031 After REQ-030, ready=1 -> codes 1,2,3,4,5,6,7 back-to-back, then valid=0.
REQ-032 Last issued code=5, req=8'b0000_0101 -> code 0 issued before code 2 (wrap order from ptr=6).
REQ-033 rst_n=0 while valid=1 and pending=8'h0C -> next edge valid=0, pending=0, code=0; no further codes issued.

Source files
------------

// File: rtl/event_pkg.sv
// event_pkg: shared sizing constants and FSM state type for the event encoder.
// Contents: NUM_REQ (request line count), CODE_W (encoded index width), state_t {IDLE, OUT}.
package event_pkg;
    localparam int NUM_REQ = 8;
    localparam int CODE_W = 3;
    typedef enum logic {IDLE, OUT} state_t;
endpackage

// File: rtl/event_encoder_if.sv
// event_encoder_if: request/issue bundle between an event source/consumer and the encoder.
// Signals: req (event pulses), ready (consumer accept), code/valid (issued event),
// pending (latched, not-yet-issued events), overflow (lost-event pulse).
// Modports: master = source/consumer side, slave = encoder side.
interface event_encoder_if;
    import event_pkg::*;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pending;
    logic [CODE_W-1:0] code;
    logic valid;
    logic ready;
    logic overflow;
    modport master(output req, ready, input code, valid, pending, overflow);
    modport slave(input req, ready, output code, valid, pending, overflow);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker over the pending vector.
// Ports: pending (candidate bits), ptr (search start) -> index (first set bit at or
// above ptr, wrapping 7->0), found (any bit set).
module rr_pick import event_pkg::*; (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [CODE_W-1:0]  ptr,
    output logic [CODE_W-1:0]  index,
    output logic               found
);
    // Scan from the farthest offset back towards ptr so the nearest set bit wins;
    // the CODE_W-bit addition provides the wrap.
    always_comb begin
        index = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            index = pending[ptr + CODE_W'(k)] ? ptr + CODE_W'(k) : index;
    end
    assign found = |pending;
endmodule

// File: rtl/event_encoder.sv
// event_encoder: latches request pulses and issues them one at a time as a binary
// code with a valid/ready handshake, round-robin among pending requests.
// Ports: clk, rst_n (sync, active-low), bus (slave: req/ready in; code, valid,
// pending, overflow out).
module event_encoder #(
    parameter int NUM_REQ = event_pkg::NUM_REQ,
    parameter int CODE_W  = event_pkg::CODE_W
) (
    input logic           clk,
    input logic           rst_n,
    event_encoder_if.slave bus
);
    import event_pkg::state_t;
    import event_pkg::IDLE;
    import event_pkg::OUT;
    state_t state, state_nxt;
    logic [NUM_REQ-1:0] pend, pend_nxt, clr;
    logic [CODE_W-1:0] code_r, code_nxt, ptr, ptr_nxt, idx;
    logic found, load, ovf, ovf_nxt;
    rr_pick u_pick (.pending(pend), .ptr(ptr), .index(idx), .found(found));
    // Selection sees only registered pending, so a req arriving this cycle is
    // merged after the cleared bit and cannot count as an overflow of itself.
    always_comb begin
        load = found && (state == IDLE || bus.ready);
        clr = load ? NUM_REQ'(1) << idx : '0;
        pend_nxt = (pend & ~clr) | bus.req;
        ovf_nxt = |(bus.req & pend & ~clr);
        state_nxt = load ? OUT : (state == OUT && bus.ready) ? IDLE : state;
        code_nxt = load ? idx : code_r;
        ptr_nxt = load ? idx + 1'b1 : ptr;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend <= '0;
            code_r <= '0;
            ptr <= '0;
            ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            pend <= pend_nxt;
            code_r <= code_nxt;
            ptr <= ptr_nxt;
            ovf <= ovf_nxt;
        end
    end
    assign bus.code = code_r;
    assign bus.valid = state == OUT;
    assign bus.pending = pend;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: directed scenarios with constant expectations plus randomized
// traffic checked against a behavioural model of the encoder.
module tb_event_encoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    event_encoder_if bus();
    event_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m_pend;
    int m_ptr, m_code;
    logic m_valid, m_ovf;

    // Observed outputs packed as {valid, code, pending, overflow}.
    function automatic logic [12:0] obs();
        return {bus.valid, bus.code, bus.pending, bus.overflow};
    endfunction

    function automatic logic [12:0] pk(logic v, int c, logic [7:0] p, logic o);
        logic [2:0] c3;
        c3 = c[2:0];
        return {v, c3, p, o};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic cycle(input logic r, input logic [7:0] q, input logic rd);
        int issue;
        rst_n = r;
        bus.req = q;
        bus.ready = rd;
        @(posedge clk);
        if (!r) begin
            m_pend = '0; m_ptr = 0; m_code = 0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            issue = -1;
            if (!m_valid || rd)
                for (int k = 7; k >= 0; k--)
                    if (m_pend[(m_ptr + k) % 8]) issue = (m_ptr + k) % 8;
            if (issue >= 0) m_pend[issue] = 1'b0;
            m_ovf = |(q & m_pend);
            m_pend = m_pend | q;
            if (issue >= 0) begin
                m_valid = 1'b1; m_code = issue; m_ptr = (issue + 1) % 8;
            end else if (m_valid && rd) m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (obs() !== 13'h0) begin
            n_bad++; $display("FAIL reset: got %h want %h", obs(), 13'h0);
        end
    endtask

    task automatic test_single();
        logic [7:0] q [3] = '{8'h08, 8'h00, 8'h00};
        logic [12:0] e [3];
        e = '{pk(0, 0, 8'h08, 0), pk(1, 3, 8'h00, 0), pk(0, 3, 8'h00, 0)};
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, q[i], 1'b1);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++; $display("FAIL single step %0d: got %h want %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [4] = '{8'h81, 8'h00, 8'h00, 8'h00};
        logic [12:0] e [4];
        e = '{pk(0, 0, 8'h81, 0), pk(1, 0, 8'h80, 0), pk(1, 7, 8'h00, 0), pk(0, 7, 8'h00, 0)};
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, q[i], 1'b1);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++; $display("FAIL back_to_back step %0d: got %h want %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_hold_overflow();
        logic [7:0] r;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        n_cmp++;
        if (obs() !== pk(0, 0, 8'hFF, 0)) begin
            n_bad++; $display("FAIL hold latch: got %h want %h", obs(), pk(0, 0, 8'hFF, 0));
        end
        cycle(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (obs() !== pk(1, 0, 8'hFE, 0)) begin
            n_bad++; $display("FAIL hold load: got %h want %h", obs(), pk(1, 0, 8'hFE, 0));
        end
        for (int i = 0; i < 5; i++) begin
            r = 8'($urandom_range(1, 127)) << 1;
            cycle(1'b1, r, 1'b0);
            n_cmp++;
            if (obs() !== pk(1, 0, 8'hFE, 1)) begin
                n_bad++; $display("FAIL hold cycle %0d req %h: got %h want %h", i, r, obs(), pk(1, 0, 8'hFE, 1));
            end
        end
    endtask

    task automatic test_drain();
        logic [7:0] p;
        for (int k = 1; k <= 7; k++) begin
            p = 8'hFF << (k + 1);
            cycle(1'b1, 8'h00, 1'b1);
            n_cmp++;
            if (obs() !== pk(1, k, p, 0)) begin
                n_bad++; $display("FAIL drain code %0d: got %h want %h", k, obs(), pk(1, k, p, 0));
            end
        end
        cycle(1'b1, 8'h00, 1'b1);
        n_cmp++;
        if (obs() !== pk(0, 7, 8'h00, 0)) begin
            n_bad++; $display("FAIL drain end: got %h want %h", obs(), pk(0, 7, 8'h00, 0));
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q [6] = '{8'h20, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        logic [12:0] e [6];
        e = '{pk(0, 0, 8'h20, 0), pk(1, 5, 8'h00, 0), pk(0, 5, 8'h05, 0),
              pk(1, 0, 8'h04, 0), pk(1, 2, 8'h00, 0), pk(0, 2, 8'h00, 0)};
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, q[i], 1'b1);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++; $display("FAIL wrap step %0d: got %h want %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] q [7] = '{8'h08, 8'h08, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10};
        logic rd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [12:0] e [7];
        e = '{pk(0, 0, 8'h08, 0), pk(1, 3, 8'h08, 0), pk(1, 3, 8'h00, 0), pk(0, 3, 8'h00, 0),
              pk(0, 3, 8'h10, 0), pk(1, 4, 8'h10, 0), pk(1, 4, 8'h10, 1)};
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, q[i], rd[i]);
            n_cmp++;
            if (obs() !== e[i]) begin
                n_bad++; $display("FAIL boundary step %0d: got %h want %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h0D, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        n_cmp++;
        if (obs() !== pk(1, 0, 8'h0C, 0)) begin
            n_bad++; $display("FAIL reset_mid setup: got %h want %h", obs(), pk(1, 0, 8'h0C, 0));
        end
        cycle(1'b0, 8'hFF, 1'b0);
        n_cmp++;
        if (obs() !== 13'h0) begin
            n_bad++; $display("FAIL reset_mid clear: got %h want %h", obs(), 13'h0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h00, 1'b1);
            n_cmp++;
            if (obs() !== 13'h0) begin
                n_bad++; $display("FAIL reset_mid idle %0d: got %h want %h", i, obs(), 13'h0);
            end
        end
    endtask

    task automatic test_random();
        logic r, rd;
        logic [7:0] q;
        logic [12:0] e;
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 49) != 0;
            q = 8'($urandom & $urandom & $urandom);
            rd = $urandom_range(0, 3) != 0;
            cycle(r, q, rd);
            e = pk(m_valid, m_code, m_pend, m_ovf);
            n_cmp++;
            if (obs() !== e) begin
                n_bad++; $display("FAIL random cycle %0d: got %h want %h", i, obs(), e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_overflow();
        test_drain();
        test_wrap();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
